// File: rtl/jtframe_db9_scan.sv
// Scans NJOY DB9 joystick ports sharing one SELECT line, auto-detecting Atari,
// Megadrive 3-button and 6-button pads, and publishes decoded words once per scan.
module jtframe_db9_scan_lane (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  pins,      // {p5,p4,right,left,down,up}, active low
  input  logic        smp_ph0,
  input  logic        smp_ph1,
  input  logic        smp_ph5,
  input  logic        smp_ph6,
  input  logic        latch,
  output logic [11:0] joy_out,   // {mode,z,y,x,start,c,b,a,up,down,left,right}
  output logic [1:0]  joy_type
);
  logic [5:0]  s1, s2;
  logic [11:0] sh;
  logic        md_det, six_det;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= 6'h3f;
      s2       <= 6'h3f;
      sh       <= '0;
      md_det   <= 1'b0;
      six_det  <= 1'b0;
      joy_out  <= '0;
      joy_type <= '0;
    end else begin
      s1 <= pins;
      s2 <= s1;
      if (smp_ph0) begin
        sh[3:0] <= {~s2[0], ~s2[1], ~s2[2], ~s2[3]};
        sh[5]   <= ~s2[4];
        sh[6]   <= ~s2[5];
      end
      if (smp_ph1) begin
        md_det <= ~s2[2] & ~s2[3];
        sh[4]  <= ~s2[4];
        sh[7]  <= ~s2[5];
      end
      if (smp_ph5) six_det <= (s2[3:0] == 4'h0);
      // Extra buttons appear on the direction pins only after the third low pulse
      if (smp_ph6 && six_det)
        sh[11:8] <= {~s2[3], ~s2[0], ~s2[1], ~s2[2]};
      if (latch) begin
        if (six_det) begin
          joy_out  <= sh;
          joy_type <= 2'd2;
        end else if (md_det) begin
          joy_out  <= {4'b0, sh[7:0]};
          joy_type <= 2'd1;
        end else begin
          joy_out  <= {5'b0, sh[6:5], 1'b0, sh[3:0]};
          joy_type <= 2'd0;
        end
      end
    end
  end
endmodule

module jtframe_db9_scan #(
  parameter int NJOY      = 2,
  parameter int PHASE_CYC = 256,
  parameter int IDLE_CYC  = 98304,
  parameter int MD_EN     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6*NJOY-1:0]   joy_bus,
  output logic                joy_select,
  output logic [12*NJOY-1:0]  joy_out,
  output logic [2*NJOY-1:0]   joy_type,
  output logic                scan_done
);
  localparam int MAXC = (PHASE_CYC > IDLE_CYC) ? PHASE_CYC : IDLE_CYC;
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] PH_LAST   = CW'(PHASE_CYC - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYC - 1);

  typedef enum logic [3:0] {
    IDLE, PH0, PH1, PH2, PH3, PH4, PH5, PH6, PH7, LATCH
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          in_ph, ph_end, odd_ph;

  logic [NJOY-1:0][5:0]  bus_l;
  logic [NJOY-1:0][11:0] out_l;
  logic [NJOY-1:0][1:0]  type_l;

  assign in_ph  = (state >= PH0) && (state <= PH7);
  assign ph_end = in_ph && (cnt == PH_LAST);
  assign odd_ph = (state == PH1) || (state == PH3) || (state == PH5) || (state == PH7);
  assign joy_select = (MD_EN == 0) ? 1'b1 : ~odd_ph;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      scan_done <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      scan_done <= (state == LATCH);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    case (state)
      IDLE: if (cnt == IDLE_LAST) begin
        state_nx = PH0;
        cnt_nx   = '0;
      end
      LATCH: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
      default: if (ph_end) begin
        cnt_nx   = '0;
        // Without Megadrive support the scan is a single SELECT-high phase
        state_nx = (state == PH7 || MD_EN == 0) ? LATCH : state_t'(state + 4'd1);
      end
    endcase
  end

  assign bus_l    = joy_bus;
  assign joy_out  = out_l;
  assign joy_type = type_l;

  genvar g;
  generate
    for (g = 0; g < NJOY; g++) begin : g_lane
      jtframe_db9_scan_lane u_lane (
        .clk      (clk),
        .rst      (rst),
        .pins     (bus_l[g]),
        .smp_ph0  (ph_end && state == PH0),
        .smp_ph1  (ph_end && state == PH1),
        .smp_ph5  (ph_end && state == PH5),
        .smp_ph6  (ph_end && state == PH6),
        .latch    (state == LATCH),
        .joy_out  (out_l[g]),
        .joy_type (type_l[g])
      );
    end
  endgenerate
endmodule

// File: tb/tb_jtframe_db9_scan.sv
// Directed bench: pad models on a 2-port Megadrive-enabled scanner plus an
// Atari-only single-port build sharing clock and reset.
module tb_jtframe_db9_scan;
  localparam int PH = 8, ID = 40, PERIOD = 8*PH + ID + 1;
  localparam int PH1C = 4, ID1 = 16, PERIOD1 = PH1C + ID1 + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] joy_bus;
  logic        joy_select, scan_done;
  logic [23:0] joy_out;
  logic [3:0]  joy_type;
  logic [5:0]  joy_bus1;
  logic        joy_select1, scan_done1;
  logic [11:0] joy_out1;
  logic [1:0]  joy_type1;

  int checks = 0, failures = 0;
  int k0 = 0, k1 = 0;           // 0 open, 1 Atari, 2 MD 3-btn, 3 MD 6-btn
  logic [11:0] b0 = '0, b1 = '0;
  int lows = 0;
  logic prev_sel = 1'b1;
  int p1_cnt = 0, p1_last = 0;
  logic sel1_low = 1'b0;

  always #5 clk = ~clk;

  jtframe_db9_scan #(.NJOY(2), .PHASE_CYC(PH), .IDLE_CYC(ID), .MD_EN(1)) u_dut (
    .clk(clk), .rst(rst), .joy_bus(joy_bus), .joy_select(joy_select),
    .joy_out(joy_out), .joy_type(joy_type), .scan_done(scan_done));

  jtframe_db9_scan #(.NJOY(1), .PHASE_CYC(PH1C), .IDLE_CYC(ID1), .MD_EN(0)) u_atari (
    .clk(clk), .rst(rst), .joy_bus(joy_bus1), .joy_select(joy_select1),
    .joy_out(joy_out1), .joy_type(joy_type1), .scan_done(scan_done1));

  // Pin model: buttons b in output order {mode,z,y,x,start,c,b,a,up,down,left,right}
  function automatic logic [5:0] pad(input int kind, input logic [11:0] b,
                                     input logic sel, input int nlow);
    logic six;
    six = (kind == 3) && (nlow == 3);
    case (kind)
      1: pad = ~{b[6], b[5], b[0], b[1], b[2], b[3]};
      2, 3: begin
        if (sel) pad = six ? ~{b[6], b[5], b[11], b[8], b[9], b[10]}
                           : ~{b[6], b[5], b[0], b[1], b[2], b[3]};
        else     pad = six ? {~b[7], ~b[4], 4'b0000}
                           : {~b[7], ~b[4], 2'b00, ~b[2], ~b[3]};
      end
      default: pad = 6'h3f;
    endcase
  endfunction

  assign joy_bus  = {pad(k1, b1, joy_select, lows), pad(k0, b0, joy_select, lows)};
  assign joy_bus1 = 6'h00;   // Atari pad with every direction and both fires held

  always @(posedge clk) begin
    prev_sel <= joy_select;
    if (rst || scan_done) lows <= 0;
    else if (prev_sel && !joy_select) lows <= lows + 1;
  end

  always @(posedge clk) begin
    if (rst) p1_cnt <= 0;
    else if (scan_done1) begin
      p1_last <= p1_cnt;
      p1_cnt  <= 1;
    end else p1_cnt <= p1_cnt + 1;
  end

  always @(negedge clk)
    if (!rst && joy_select1 == 1'b0) sel1_low <= 1'b1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int maxc, output int n, output bit changed);
    logic [23:0] ref_out;
    ref_out = joy_out;
    n = 0;
    changed = 1'b0;
    while (n < maxc) begin
      @(posedge clk);
      #1;
      n++;
      if (scan_done) break;
      if (joy_out !== ref_out) changed = 1'b1;
    end
    chk("scan_done_seen", {31'd0, scan_done}, 32'd1);
  endtask

  typedef struct {
    int k0; logic [11:0] b0;
    int k1; logic [11:0] b1;
    logic [11:0] e0; logic [1:0] t0;
    logic [11:0] e1; logic [1:0] t1;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    bit changed;
    logic stable;

    vecs[0] = '{1, 12'h028, 0, 12'h000, 12'h028, 2'd0, 12'h000, 2'd0}; // Atari up+fire on p4
    vecs[1] = '{1, 12'h048, 0, 12'h000, 12'h048, 2'd0, 12'h000, 2'd0}; // Atari up+fire on p5
    vecs[2] = '{0, 12'h000, 2, 12'h090, 12'h000, 2'd0, 12'h090, 2'd1}; // MD3 A+Start
    vecs[3] = '{3, 12'h901, 2, 12'h0F1, 12'h901, 2'd2, 12'h0F1, 2'd1}; // MD6 X+Mode+right
    vecs[4] = '{1, 12'h00C, 1, 12'h06E, 12'h00C, 2'd0, 12'h06E, 2'd0}; // Atari up+down passes
    vecs[5] = '{3, 12'hFFF, 0, 12'h000, 12'hFFF, 2'd2, 12'h000, 2'd0}; // MD6 everything
    vecs[6] = '{0, 12'h000, 0, 12'h000, 12'h000, 2'd0, 12'h000, 2'd0}; // unplugged

    // Reset state and first-scan latency
    step(3);
    chk("rst_joy_out", {8'd0, joy_out}, 32'd0);
    chk("rst_joy_type", {28'd0, joy_type}, 32'd0);
    chk("rst_select", {31'd0, joy_select}, 32'd1);
    chk("rst_scan_done", {31'd0, scan_done}, 32'd0);
    chk("rst_atari_out", {20'd0, joy_out1}, 32'd0);
    rst = 1'b0;
    wait_done(PERIOD + 20, n, changed);
    chk("first_scan_latency", n, PERIOD);
    chk("first_scan_out", {8'd0, joy_out}, 32'd0);

    // Table: program models right after a scan, check after the next full scan
    for (int i = 0; i < 7; i++) begin
      k0 = vecs[i].k0; b0 = vecs[i].b0;
      k1 = vecs[i].k1; b1 = vecs[i].b1;
      wait_done(PERIOD + 20, n, changed);
      chk($sformatf("v%0d_period", i), n, PERIOD);
      chk($sformatf("v%0d_out0", i), {20'd0, joy_out[11:0]}, {20'd0, vecs[i].e0});
      chk($sformatf("v%0d_type0", i), {30'd0, joy_type[1:0]}, {30'd0, vecs[i].t0});
      chk($sformatf("v%0d_out1", i), {20'd0, joy_out[23:12]}, {20'd0, vecs[i].e1});
      chk($sformatf("v%0d_type1", i), {30'd0, joy_type[3:2]}, {30'd0, vecs[i].t1});
    end

    // Mid-scan button change: a/start were sampled in PH1, so the change shows one scan later
    k0 = 2; b0 = 12'h010;
    wait_done(PERIOD + 20, n, changed);
    chk("mid_prior_out", {20'd0, joy_out[11:0]}, 32'h010);
    stable = 1'b1;
    repeat (ID + 3*PH + 4) begin
      step(1);
      if (joy_out[11:0] !== 12'h010) stable = 1'b0;
    end
    chk("mid_ph3_select", {31'd0, joy_select}, 32'd0);
    chk("mid_hold_before", {31'd0, stable}, 32'd1);
    b0 = 12'h080;
    wait_done(PERIOD + 20, n, changed);
    chk("mid_no_partial", {31'd0, changed}, 32'd0);
    chk("mid_same_scan_out", {20'd0, joy_out[11:0]}, 32'h010);
    step(1);
    chk("mid_done_width", {31'd0, scan_done}, 32'd0);
    wait_done(PERIOD + 20, n, changed);
    chk("mid_next_scan_out", {20'd0, joy_out[11:0]}, 32'h080);
    chk("mid_next_scan_type", {30'd0, joy_type[1:0]}, 32'd1);

    // Reset in PH4, then a clean full scan
    k0 = 3; b0 = 12'h901;
    step(ID + 4*PH + 3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_mid_select", {31'd0, joy_select}, 32'd1);
    chk("rst_mid_out", {8'd0, joy_out}, 32'd0);
    chk("rst_mid_type", {28'd0, joy_type}, 32'd0);
    wait_done(PERIOD + 20, n, changed);
    chk("rst_mid_latency", n, PERIOD);
    chk("rst_mid_out0", {20'd0, joy_out[11:0]}, 32'h901);
    chk("rst_mid_type0", {30'd0, joy_type[1:0]}, 32'd2);

    // Atari-only build
    chk("atari_out", {20'd0, joy_out1}, 32'h06F);
    chk("atari_type", {30'd0, joy_type1}, 32'd0);
    chk("atari_period", p1_last, PERIOD1);
    chk("atari_select_never_low", {31'd0, sel1_low}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
